vga_palette: RTL

Writable, parametrised colour palette for the VGA output path. Maps a pixel index from the frame-buffer pipeline to per-channel RGB through a 2^IDX_W-entry palette RAM the CPU can rewrite at run time. After reset an internal sequencer loads the 16-colour CGA default palette. Sits between the pixel fetch stage and the DAC/pin drivers, with a two-cycle registered pixel path and blanking alignment.

---
 rtl/vga_palette.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/vga_palette.sv
// Writable VGA colour palette: two-stage pixel lookup, CPU write/readback, CGA default loader.
// Optional readback port enabled by defining VGA_PALETTE_READBACK_EN.
module vga_palette #(
  parameter int IDX_W = 4,
  parameter int CH_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    pix_idx,
  input  logic                pix_blank,
  output logic [CH_W-1:0]     pix_r,
  output logic [CH_W-1:0]     pix_g,
  output logic [CH_W-1:0]     pix_b,
  output logic                pix_blank_o,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_addr,
  input  logic [3*CH_W-1:0]   wr_data,
  output logic                wr_ready,
  input  logic                rd_en,
  input  logic [IDX_W-1:0]    rd_addr,
  output logic [3*CH_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                pal_reload,
  output logic                init_busy
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int PW    = 3 * CH_W;
  localparam int REP   = (CH_W + 3) / 4;

  typedef enum logic {INIT, RUN} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   cnt_reg, cnt_next;
  logic [PW-1:0]      pal_mem [DEPTH];
  logic [IDX_W-1:0]   idx_s1_reg;
  logic               blank_s1_reg;
  logic               wr_accept;

  // Nibble widened by repetition so full-scale stays full-scale (a -> aa).
  function automatic logic [CH_W-1:0] widen(input logic [3:0] n);
    logic [4*REP-1:0] rep;
    rep = {REP{n}};
    return rep[4*REP-1 -: CH_W];
  endfunction

  function automatic logic [11:0] cga(input logic [3:0] i);
    logic [11:0] c;
    c = 12'h000;
    case (i)
      4'h0: c = 12'h000;
      4'h1: c = 12'h00a;
      4'h2: c = 12'h0a0;
      4'h3: c = 12'h0aa;
      4'h4: c = 12'ha00;
      4'h5: c = 12'ha0a;
      4'h6: c = 12'ha50;
      4'h7: c = 12'haaa;
      4'h8: c = 12'h555;
      4'h9: c = 12'h55f;
      4'ha: c = 12'h5f5;
      4'hb: c = 12'h5ff;
      4'hc: c = 12'hf55;
      4'hd: c = 12'hf5f;
      4'he: c = 12'hff5;
      4'hf: c = 12'hfff;
    endcase
    return c;
  endfunction

  function automatic logic [PW-1:0] default_entry(input logic [IDX_W-1:0] i);
    logic [11:0] c;
    c = cga(i[3:0]);
    return {widen(c[11:8]), widen(c[7:4]), widen(c[3:0])};
  endfunction

  assign init_busy = (state_reg == INIT);
  assign wr_ready  = (state_reg == RUN);
  // A reload in the same cycle as a write wins; the write is lost.
  assign wr_accept = wr_en && wr_ready && !pal_reload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      INIT: begin
        if (pal_reload) begin
          cnt_next = '0;
        end else if (cnt_reg == IDX_W'(DEPTH - 1)) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + IDX_W'(1);
        end
      end
      RUN: begin
        if (pal_reload) begin
          state_next = INIT;
          cnt_next   = '0;
        end
      end
    endcase
  end

  // Palette RAM is never reset; the sequencer rewrites it after every reset.
  always_ff @(posedge clk) begin
    if (state_reg == INIT) begin
      pal_mem[cnt_reg] <= default_entry(cnt_reg);
    end else if (wr_accept) begin
      pal_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_s1_reg   <= '0;
      blank_s1_reg <= 1'b1;
      pix_r        <= '0;
      pix_g        <= '0;
      pix_b        <= '0;
      pix_blank_o  <= 1'b1;
    end else begin
      idx_s1_reg   <= pix_idx;
      blank_s1_reg <= pix_blank;
      pix_blank_o  <= blank_s1_reg;
      if (blank_s1_reg || state_reg == INIT) begin
        {pix_r, pix_g, pix_b} <= '0;
      end else begin
        {pix_r, pix_g, pix_b} <= pal_mem[idx_s1_reg];
      end
    end
  end

`ifdef VGA_PALETTE_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en && (state_reg == RUN);
      if (rd_en && state_reg == RUN) begin
        rd_data <= pal_mem[rd_addr];
      end
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^{rd_en, rd_addr};
  assign rd_data   = '0;
  assign rd_valid  = 1'b0;
`endif

endmodule
